// File: rtl/adder_arbiter_32.sv
// Purpose : shares one 32-bit ripple-carry adder between two requesters; 32-bit ops take one pass, 64-bit ops take two passes with a registered carry.
// Latency : handshake in cycle 0 -> rsp_valid in cycle 2 (narrow) or cycle 3 (wide); one op per 3 (narrow) / 4 (wide) cycles.
// Backpressure: response held stable in RESP until rsp_ready; no request is accepted outside IDLE.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]    per-requester request handshake (ready is one-hot or zero, IDLE only)
//   req_a0/b0, req_a1/b1 [63:0] operands (upper halves used only for wide ops)
//   req_cin, req_wide [1:0]     per-requester carry-in and 64-bit select
//   rsp_valid/rsp_ready         response handshake
//   rsp_id, rsp_sum, rsp_cout   owner, 64-bit result, final carry-out
//   op_count [15:0]             completed responses, wraps at 16 bits

// Purpose : 32-bit ripple-carry adder shared by the arbiter.
// Latency : combinational.
// Backpressure: none.
module full_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module adder_arbiter_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a0,
    input  logic [63:0] req_b0,
    input  logic [63:0] req_a1,
    input  logic [63:0] req_b1,
    input  logic [1:0]  req_cin,
    input  logic [1:0]  req_wide,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;          // requester served last
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        wide_q, wide_d;
    logic        id_q, id_d;
    logic        carry_q, carry_d;      // carry between the low and high pass
    logic [63:0] rsp_sum_q, rsp_sum_d;
    logic        rsp_cout_q, rsp_cout_d;
    logic [15:0] op_count_q, op_count_d;

    logic [1:0]  grant;
    logic        req_hs;
    logic        hs_id;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    full_adder_32 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Gated by rst_n so no grant is visible while reset is held.
    assign req_ready = (state_q == ST_IDLE && rst_n) ? grant : 2'b00;
    assign req_hs    = |(req_valid & req_ready);
    assign hs_id     = req_ready[1];

    // The adder sees zeros except during its two working states.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_LO: begin
                add_a   = a_q[31:0];
                add_b   = b_q[31:0];
                add_cin = cin_q;
            end
            ST_HI: begin
                add_a   = a_q[63:32];
                add_b   = b_q[63:32];
                add_cin = carry_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        wide_d     = wide_q;
        id_d       = id_q;
        carry_d    = carry_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        op_count_d = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    a_d     = hs_id ? req_a1 : req_a0;
                    b_d     = hs_id ? req_b1 : req_b0;
                    cin_d   = req_cin[hs_id];
                    wide_d  = req_wide[hs_id];
                    id_d    = hs_id;
                    ptr_d   = hs_id;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                // Upper half cleared here; a wide op overwrites it in HI.
                rsp_sum_d  = {32'h0, add_sum};
                rsp_cout_d = add_cout;
                carry_d    = add_cout;
                state_d    = wide_q ? ST_HI : ST_RESP;
            end
            ST_HI: begin
                rsp_sum_d  = {add_sum, rsp_sum_q[31:0]};
                rsp_cout_d = add_cout;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            wide_q     <= 1'b0;
            id_q       <= 1'b0;
            carry_q    <= 1'b0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            wide_q     <= wide_d;
            id_q       <= id_d;
            carry_q    <= carry_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_adder_arbiter_32.sv
// Purpose : directed self-checking bench for adder_arbiter_32.
// Latency : n/a.
// Backpressure: exercises held responses with rsp_ready low.
module tb_adder_arbiter_32;
    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_cin;
    logic [1:0]  req_wide;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
    logic [15:0] op_count;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count;

    adder_arbiter_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_cin   (req_cin),
        .req_wide  (req_wide),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".rsp_valid"}, rsp_valid, 0);
        chk({tag, ".rsp_id"},    rsp_id,    0);
        chk({tag, ".rsp_sum"},   rsp_sum,   0);
        chk({tag, ".rsp_cout"},  rsp_cout,  0);
        chk({tag, ".op_count"},  op_count,  0);
        chk({tag, ".req_ready"}, req_ready, 0);
    endtask

    // One complete op from a single requester with rsp_ready held high.
    task automatic run_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic wide,
                          input logic [63:0] exp_sum, input logic exp_cout, input string tag);
        int n;
        if (id) begin
            req_a1 = a; req_b1 = b;
        end else begin
            req_a0 = a; req_b0 = b;
        end
        req_cin   = {cin, cin};
        req_wide  = {wide, wide};
        req_valid = id ? 2'b10 : 2'b01;
        rsp_ready = 1'b1;
        #1;
        chk({tag, ".grant"}, req_ready, id ? 2'b10 : 2'b01);
        step();
        req_valid = 2'b00;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, n, wide ? 3 : 2);
        chk({tag, ".sum"},  rsp_sum,  exp_sum);
        chk({tag, ".cout"}, rsp_cout, exp_cout);
        chk({tag, ".id"},   rsp_id,   id);
        step();
        exp_count++;
        chk({tag, ".count"}, op_count, exp_count);
        chk({tag, ".idle"},  rsp_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_cin   = 2'b00;
        req_wide  = 2'b00;
        rsp_ready = 1'b0;
        exp_count = 16'h0000;

        // Reset held with both requesters asking: nothing is granted.
        repeat (3) step();
        chk_outputs_zero("reset");
        rst_n     = 1'b1;
        req_valid = 2'b00;
        repeat (3) step();
        chk_outputs_zero("idle");

        // Narrow, requester 0: 5 + 3 + 1 = 9.
        run_op(1'b0, 64'h5, 64'h3, 1'b1, 1'b0, 64'h9, 1'b0, "narrow0");
        // Wide carry across the halves.
        run_op(1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1,
               64'h0000_0001_0000_0000, 1'b0, "wide_carry");
        // Wide all-ones plus carry-in: full wrap with carry-out.
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "wide_ones");
        // Narrow ignores upper operand halves.
        run_op(1'b0, 64'hDEAD_BEEF_0000_0010, 64'h1234_5678_0000_0020, 1'b0, 1'b0,
               64'h30, 1'b0, "narrow_upper");
        // Narrow overflow: sum wraps to zero, carry reported, upper half stays zero.
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h0, 1'b1, "narrow_ovf");

        // Arbitration: both valid for 4 ops, last served was 1 -> order 0,1,0,1.
        req_a0 = 64'd1;  req_b0 = 64'd1;
        req_a1 = 64'd10; req_b1 = 64'd20;
        req_cin = 2'b00; req_wide = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic eid;
            eid = (k % 2 == 1);
            chk("arb.grant", req_ready, eid ? 2'b10 : 2'b01);
            step();
            chk("arb.lo_ready", req_ready, 0);
            step();
            chk("arb.resp_valid", rsp_valid, 1);
            chk("arb.resp_id",    rsp_id,    eid);
            chk("arb.resp_sum",   rsp_sum,   eid ? 64'd30 : 64'd2);
            chk("arb.resp_ready", req_ready, 0);
            step();
            exp_count++;
        end
        req_valid = 2'b00;
        chk("arb.count", op_count, exp_count);

        // Backpressure: response held 5 cycles with requests pending.
        req_a0 = 64'h100; req_b0 = 64'h200;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        chk("bp.grant", req_ready, 2'b01);
        step();
        req_a1 = 64'h7; req_b1 = 64'h8;
        req_valid = 2'b11;
        #1;
        chk("bp.lo_ready", req_ready, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", rsp_valid, 1);
            chk("bp.sum",   rsp_sum,   64'h300);
            chk("bp.id",    rsp_id,    0);
            chk("bp.cout",  rsp_cout,  0);
            chk("bp.ready", req_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("bp.still_valid", rsp_valid, 1);
        step();
        exp_count++;
        chk("bp.idle",  rsp_valid, 0);
        chk("bp.count", op_count, exp_count);
        req_valid = 2'b11;
        #1;
        chk("bp.next_grant", req_ready, 2'b10);
        req_valid = 2'b00;

        // Reset in HI of a wide op from requester 0; pointer must return to 1.
        req_a0 = 64'hFFFF_FFFF_FFFF_FFFF; req_b0 = 64'h1;
        req_wide = 2'b11;
        req_valid = 2'b01;
        #1;
        chk("rst_hi.grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk_outputs_zero("rst_hi");
        step();
        step();
        chk("rst_hi.no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        exp_count = 16'h0000;
        #1;
        chk("rst_hi.ptr", req_ready, 2'b01);
        chk("rst_hi.count", op_count, 0);
        req_valid = 2'b00;
        req_wide  = 2'b00;
        repeat (4) step();
        chk("rst_hi.quiet", rsp_valid, 0);

        // Counter wrap: preload 0xFFFF, then two ops -> 0x0000, 0x0001.
        force dut.op_count_q = 16'hFFFF;
        step();
        release dut.op_count_q;
        exp_count = 16'hFFFF;
        #1;
        chk("wrap.preload", op_count, 16'hFFFF);
        run_op(1'b0, 64'h2, 64'h2, 1'b0, 1'b0, 64'h4, 1'b0, "wrap0");
        run_op(1'b1, 64'h3, 64'h4, 1'b1, 1'b0, 64'h8, 1'b0, "wrap1");
        chk("wrap.final", op_count, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_arbiter_32.md
# adder_arbiter_32

Shares one instance of the team's 32-bit ripple-carry adder (`full_adder_32`) between two requesters. Each request is a 32-bit add, or a 64-bit add sequenced as two passes through the adder with the carry held in a register between passes. A round-robin arbiter grants requesters. A single response channel with backpressure returns the result tagged with the requester id. The block sits between the datapath clients and the shared adder, and is the only driver of that adder's inputs.

## Interface
- No parameters; widths fixed (adder 32 b, operands 64 b).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle, bit i = requester i
- req_a0, req_b0  in  64  requester 0 operands (bits 63:32 ignored unless req_wide0)
- req_a1, req_b1  in  64  requester 1 operands
- req_cin  in  2  carry-in per requester
- req_wide  in  2  1 = 64-bit op (two passes), 0 = 32-bit op
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_sum  out  64  result
- rsp_cout  out  1  final carry-out
- op_count  out  16  count of completed responses

## Operation
- The FSM has four states: IDLE, LO, HI, RESP.
- **IDLE**
  - The arbiter picks one requester with req_valid set.
  - If both are valid, it picks the one not served last. The last-served pointer resets to 1, so requester 0 wins first.
  - req_ready[i] is high only in IDLE and only for the picked i. It is combinational on req_valid and the pointer, and is one-hot or zero.
  - On handshake (req_valid[i] & req_ready[i]) the block latches the operands, cin, wide and id, updates the pointer to i, and goes to LO.
- **LO**
  - Adder inputs: a[31:0], b[31:0], cin.
  - Registers the 32-bit sum into rsp_sum[31:0] and the carry into carry_q.
  - Next state: HI if wide, else RESP. A narrow op forces rsp_sum[63:32]=0 and rsp_cout=carry.
- **HI**
  - Adder inputs: a[63:32], b[63:32], carry_q.
  - Registers rsp_sum[63:32] and rsp_cout = adder cout.
  - Next state: RESP.
- **RESP**
  - rsp_valid=1. rsp_id, rsp_sum and rsp_cout hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: op_count increments (16-bit wrap, 0xFFFF→0x0000) and the FSM returns to IDLE.
- The adder inputs are driven to 0 outside LO and HI.
- Arithmetic is modulo 2^32 (narrow) or 2^64 (wide); the carry-out is reported, never sign-extended.

## Timing
- Reset (async assert, sync deassert by the system):
  - state=IDLE, pointer=1.
  - req_ready=0 while rst_n is low.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, op_count=0, carry_q=0.
- Latency, handshake in cycle 0:
  - Narrow: rsp_valid is high in cycle 2.
  - Wide: rsp_valid is high in cycle 3.
- Throughput, with rsp_ready held high:
  - Narrow: one op per 3 cycles.
  - Wide: one op per 4 cycles.
- No new request is accepted from LO through the RESP handshake. req_ready is 0 in all non-IDLE states.
- Once rsp_valid is asserted it stays high until accepted.
- The response handshake and the next request handshake never coincide. After a response handshake, IDLE arbitration happens in the following cycle.
- Simultaneous valids: exactly one is granted and the other waits. A requester that drops valid before being granted is simply not served.
- Requesters must hold operands stable only until their own handshake. The block latches them.
- Reset mid-operation (LO, HI or RESP): the operation is abandoned with no response and all state returns to reset values immediately.
- Critical path: one 32-bit ripple carry per cycle. The carry between halves is registered, never chained combinationally.

## Test plan
- Reset, then an idle period:
  - All outputs 0.
  - A narrow request from requester 0 (a=0x00000005, b=0x00000003, cin=1) handshakes in cycle 0.
  - Required: rsp_valid in cycle 2 with rsp_sum=0x0000000000000009, rsp_cout=0, rsp_id=0, op_count=1 after acceptance.
- Wide carry propagation:
  - Requester 1 sends a=0x00000000FFFFFFFF, b=0x0000000000000001, cin=0, wide=1.
  - Required: rsp_sum=0x0000000100000000, rsp_cout=0, rsp_valid in cycle 3.
  - Then a=b=0xFFFFFFFFFFFFFFFF, cin=1. Required: rsp_sum=0xFFFFFFFFFFFFFFFF, rsp_cout=1.
- Arbitration: both requesters hold valid continuously for 4 ops.
  - Required grant order 0,1,0,1.
  - req_ready is one-hot and only in IDLE.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_* stays stable and req_ready stays 0.
  - The response is accepted on the first cycle rsp_ready=1, and the FSM is in IDLE the next cycle.
- Reset during HI of a wide op:
  - No response is produced and all outputs return to 0.
  - The pointer resets, so requester 0 wins the next simultaneous request.
- op_count wrap: complete 65537 narrow ops. Required: op_count=0x0001.
